// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative DIV/DIVU unit: FSM state encodings
// and the EX opcodes that the decoder maps onto start/signed_div.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'd0,
    DIV_DIVZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_t;

  localparam int unsigned EXE_OP_W = 8;

  localparam logic [EXE_OP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [EXE_OP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

  // Decoder helpers: any divide op raises start, only DIV selects signed mode
  function automatic logic is_div_op(input logic [EXE_OP_W-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic is_signed_div_op(input logic [EXE_OP_W-1:0] op);
    return op == EXE_DIV_OP;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left by one,
// trial-subtract the divisor from the upper half, keep it if non-negative.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] upper;
  logic [WIDTH:0] trial;

  // rem < divisor on entry, so the shifted upper half fits in WIDTH+1 bits
  always_comb begin
    upper    = {rem, quo[WIDTH-1]};
    trial    = upper - {1'b0, divisor};
    rem_next = upper[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next    = trial[WIDTH-1:0];
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle DIV/DIVU unit for the EX stage; result = {remainder, quotient}.
// Optional macro DIV_FAST_SMALL_EN: finish at once when |a| < |b|.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] dividend_raw;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand magnitudes; the most negative value maps onto its own bit pattern
  always_comb begin
    a_mag = (signed_div && a[WIDTH-1]) ? WIDTH'(0) - a : a;
    b_mag = (signed_div && b[WIDTH-1]) ? WIDTH'(0) - b : b;
  end

  assign quo_fix = neg_q ? WIDTH'(0) - quo_next : quo_next;
  assign rem_fix = neg_r ? WIDTH'(0) - rem_next : rem_next;

`ifdef DIV_FAST_SMALL_EN
  logic small;
  assign small = a_mag < b_mag;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Hazard hold; drops in END so EX advances on the cycle ready is high
  assign stall = ((state == DIV_IDLE) && start && !annul) ||
                 (state == DIV_ON) || (state == DIV_DIVZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DIV_IDLE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      divisor      <= '0;
      dividend_raw <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      result       <= '0;
      ready        <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        DIV_IDLE: begin
          if (start && !annul) begin
            dividend_raw <= a;
            neg_q        <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r        <= signed_div & a[WIDTH-1];
            rem          <= '0;
            quo          <= a_mag;
            divisor      <= b_mag;
            cnt          <= '0;
            if (b == '0) begin
              state <= DIV_DIVZERO;
`ifdef DIV_FAST_SMALL_EN
            end else if (small) begin
              // a itself already carries the sign the remainder needs
              state  <= DIV_END;
              result <= {a, {WIDTH{1'b0}}};
              ready  <= 1'b1;
`endif
            end else begin
              state <= DIV_ON;
            end
          end
        end

        DIV_DIVZERO: begin
          if (annul) begin
            state <= DIV_IDLE;
          end else begin
            state  <= DIV_END;
            result <= {dividend_raw, {WIDTH{1'b1}}};
            ready  <= 1'b1;
          end
        end

        DIV_ON: begin
          if (annul) begin
            state <= DIV_IDLE;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state  <= DIV_END;
              result <= {rem_fix, quo_fix};
              ready  <= 1'b1;
            end
          end
        end

        DIV_END: begin
          state <= DIV_IDLE;
        end

        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule
